// File: rtl/segway_run_ctrl_pkg.sv
// Shared types and constants for the segway run-state sequencer.
//   run_state_t      : sequencer states
//   SS_MAX           : full-scale soft-start value
//   SETTLE_TC_SLOW/FAST : steer settle terminal counts (2^25 / 2^15 clocks)
package segway_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RAMP  = 2'd1,
        ST_BAL   = 2'd2,
        ST_STEER = 2'd3
    } run_state_t;

    localparam logic [7:0]  SS_MAX         = 8'hFF;
    localparam logic [25:0] SETTLE_TC_SLOW = 26'h200_0000;
    localparam logic [25:0] SETTLE_TC_FAST = 26'h000_8000;

endpackage

// File: rtl/segway_run_ctrl_rider_detect.sv
// Rider presence and posture detection from the two load cells.
// Inputs : clk, rst_n, vld strobe, lft_ld/rght_ld (12-bit unsigned)
// Outputs: rider_off  - hysteretic no-rider flag (registered, updated on vld)
//          balanced   - last sample had diff < sum/4 (registered)
//          step_off   - last sample had diff > 15/16 of sum (registered)
//          rider_off_d, step_off_d - values being captured this cycle, so a
//          consumer can react on the same edge that stores the sample
module rider_detect #(
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        rider_off,
    output logic        balanced,
    output logic        step_off,
    output logic        rider_off_d,
    output logic        step_off_d
);

    // Thresholds are 13 bits wide to compare against the 13-bit sum;
    // WT_HYST is assumed not to exceed MIN_RIDER_WT.
    localparam logic [12:0] THR_ON  = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
    localparam logic [12:0] THR_OFF = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    logic [12:0] sum;
    logic [11:0] diff;
    logic        rider_off_q;
    logic        balanced_q, balanced_d;
    logic        step_off_q;

    always_comb begin
        sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
        diff = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);

        rider_off_d = rider_off_q;
        balanced_d  = balanced_q;
        step_off_d  = step_off_q;
        if (vld) begin
            if (sum > THR_ON) begin
                rider_off_d = 1'b0;
            end else if (sum < THR_OFF) begin
                rider_off_d = 1'b1;
            end
            balanced_d = ({1'b0, diff} < (sum >> 2));
            step_off_d = ({1'b0, diff} > (sum - (sum >> 4)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rider_off_q <= 1'b1;
            balanced_q  <= 1'b0;
            step_off_q  <= 1'b0;
        end else begin
            rider_off_q <= rider_off_d;
            balanced_q  <= balanced_d;
            step_off_q  <= step_off_d;
        end
    end

    assign rider_off = rider_off_q;
    assign balanced  = balanced_q;
    assign step_off  = step_off_q;

endmodule

// File: rtl/segway_run_ctrl.sv
// Run-state sequencer for the balance/steering math datapath.
// Inputs : clk, rst_n, pwr_req (level), vld (sample strobe), lft_ld, rght_ld,
//          too_fast (sampled on vld)
// Outputs: pwr_up, ss_tmr[7:0] soft-start scale, en_steer, rider_off,
//          ovr_spd (latched overspeed fault, cleared only through OFF)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_OFF   | datapath unpowered, ramp and counters cleared
// ST_RAMP  | powered, ss_tmr climbing one step per sample toward 255
// ST_BAL   | full scale, balancing only; waits for a settled rider
// ST_STEER | steering enabled
module segway_run_ctrl
    import segway_pkg::*;
#(
    parameter bit          FAST_SIM     = 1'b0,
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040,
    parameter int          OVR_SAMPLES  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_req,
    input  logic        vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        too_fast,
    output logic        pwr_up,
    output logic [7:0]  ss_tmr,
    output logic        en_steer,
    output logic        rider_off,
    output logic        ovr_spd
);

    localparam logic [25:0] SETTLE_TC   = FAST_SIM ? SETTLE_TC_FAST : SETTLE_TC_SLOW;
    localparam logic [25:0] SETTLE_LAST = SETTLE_TC - 26'd1;
    localparam int          OVR_W       = $clog2(OVR_SAMPLES + 1);
    localparam logic [OVR_W-1:0] OVR_MAX  = OVR_W'(OVR_SAMPLES);
    localparam logic [OVR_W-1:0] OVR_LAST = OVR_W'(OVR_SAMPLES - 1);

    run_state_t        state_q, state_d;
    logic [7:0]        ss_tmr_q, ss_tmr_d;
    logic              pwr_up_q, pwr_up_d;
    logic              en_steer_q, en_steer_d;
    logic              ovr_spd_q, ovr_spd_d;
    logic [25:0]       settle_cnt_q, settle_cnt_d;
    logic [OVR_W-1:0]  ovr_cnt_q, ovr_cnt_d;
    logic              ovr_trip;

    logic              balanced, step_off, rider_off_d, step_off_d;

    rider_detect #(
        .MIN_RIDER_WT (MIN_RIDER_WT),
        .WT_HYST      (WT_HYST)
    ) u_rider_detect (
        .clk         (clk),
        .rst_n       (rst_n),
        .vld         (vld),
        .lft_ld      (lft_ld),
        .rght_ld     (rght_ld),
        .rider_off   (rider_off),
        .balanced    (balanced),
        .step_off    (step_off),
        .rider_off_d (rider_off_d),
        .step_off_d  (step_off_d)
    );

    always_comb begin
        state_d      = state_q;
        ss_tmr_d     = ss_tmr_q;
        settle_cnt_d = settle_cnt_q;
        ovr_cnt_d    = ovr_cnt_q;
        ovr_spd_d    = ovr_spd_q;
        ovr_trip     = 1'b0;

        if (state_q != ST_OFF && vld) begin
            if (too_fast) begin
                if (ovr_cnt_q >= OVR_LAST) begin
                    ovr_trip  = 1'b1;
                    ovr_cnt_d = OVR_MAX;
                end else begin
                    ovr_cnt_d = ovr_cnt_q + 1'b1;
                end
            end else begin
                ovr_cnt_d = '0;
            end
        end

        case (state_q)
            ST_OFF: begin
                if (pwr_req) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (vld && ss_tmr_q != SS_MAX) begin
                    ss_tmr_d = ss_tmr_q + 8'd1;
                    if (ss_tmr_q == SS_MAX - 8'd1) begin
                        state_d = ST_BAL;
                    end
                end
            end
            ST_BAL: begin
                ss_tmr_d = SS_MAX;
                // The count saturates at its last value while a fault holds
                // off steering, so only the transition is gated.
                if (!rider_off && balanced) begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        if (!ovr_spd_q) begin
                            state_d      = ST_STEER;
                            settle_cnt_d = '0;
                        end
                    end else begin
                        settle_cnt_d = settle_cnt_q + 26'd1;
                    end
                end else begin
                    settle_cnt_d = '0;
                end
            end
            ST_STEER: begin
                if (vld && (rider_off_d || step_off_d)) begin
                    state_d      = ST_BAL;
                    settle_cnt_d = '0;
                end
            end
            default: state_d = ST_OFF;
        endcase

        if (ovr_trip) begin
            ovr_spd_d = 1'b1;
            state_d   = ST_BAL;
            ss_tmr_d  = SS_MAX;
        end

        if (!pwr_req) begin
            state_d      = ST_OFF;
            ss_tmr_d     = '0;
            settle_cnt_d = '0;
            ovr_cnt_d    = '0;
            ovr_spd_d    = 1'b0;
        end

        pwr_up_d   = (state_d != ST_OFF);
        en_steer_d = (state_d == ST_STEER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            ss_tmr_q     <= '0;
            pwr_up_q     <= 1'b0;
            en_steer_q   <= 1'b0;
            ovr_spd_q    <= 1'b0;
            settle_cnt_q <= '0;
            ovr_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ss_tmr_q     <= ss_tmr_d;
            pwr_up_q     <= pwr_up_d;
            en_steer_q   <= en_steer_d;
            ovr_spd_q    <= ovr_spd_d;
            settle_cnt_q <= settle_cnt_d;
            ovr_cnt_q    <= ovr_cnt_d;
        end
    end

    assign pwr_up   = pwr_up_q;
    assign ss_tmr   = ss_tmr_q;
    assign en_steer = en_steer_q;
    assign ovr_spd  = ovr_spd_q;

endmodule

// File: tb/tb_segway_run_ctrl.sv
// Directed self-checking bench for segway_run_ctrl (FAST_SIM=1, settle 2^15).
module tb_segway_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic        pwr_req;
    logic        vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        too_fast;
    logic        pwr_up;
    logic [7:0]  ss_tmr;
    logic        en_steer;
    logic        rider_off;
    logic        ovr_spd;

    int errors = 0;
    int checks = 0;

    segway_run_ctrl #(
        .FAST_SIM     (1'b1),
        .MIN_RIDER_WT (12'h200),
        .WT_HYST      (12'h040),
        .OVR_SAMPLES  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwr_req   (pwr_req),
        .vld       (vld),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .too_fast  (too_fast),
        .pwr_up    (pwr_up),
        .ss_tmr    (ss_tmr),
        .en_steer  (en_steer),
        .rider_off (rider_off),
        .ovr_spd   (ovr_spd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [11:0] l, input logic [11:0] r, input logic tf);
        lft_ld   = l;
        rght_ld  = r;
        too_fast = tf;
        vld      = 1'b1;
        step();
        vld      = 1'b0;
        too_fast = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        pwr_req  = 1'b0;
        vld      = 1'b0;
        lft_ld   = 12'h000;
        rght_ld  = 12'h000;
        too_fast = 1'b0;
        step();
        step();
        chk("rst_pwr_up",    pwr_up,    0);
        chk("rst_ss_tmr",    ss_tmr,    0);
        chk("rst_en_steer",  en_steer,  0);
        chk("rst_rider_off", rider_off, 1);
        chk("rst_ovr_spd",   ovr_spd,   0);
        rst_n = 1'b1;
        step();
        chk("off_idle_pwr_up", pwr_up, 0);

        // Soft-start ramp with no rider on the cells
        pwr_req = 1'b1;
        step();
        chk("ramp_pwr_up", pwr_up, 1);
        chk("ramp_ss_start", ss_tmr, 8'h00);
        for (int i = 0; i < 254; i++) begin
            pulse(12'h000, 12'h000, 1'b0);
            step();
        end
        chk("ramp_ss_254", ss_tmr, 8'hFE);
        pulse(12'h000, 12'h000, 1'b0);
        chk("ramp_ss_255", ss_tmr, 8'hFF);
        for (int i = 0; i < 45; i++) begin
            pulse(12'h000, 12'h000, 1'b0);
        end
        chk("ramp_no_wrap", ss_tmr, 8'hFF);
        chk("bal_pwr_up", pwr_up, 1);
        chk("bal_en_steer", en_steer, 0);

        // Settle: balanced rider, disturbed mid-count, then a clean 2^15 run
        pulse(12'h300, 12'h300, 1'b0);
        chk("rider_on", rider_off, 0);
        repeat (1000) step();
        chk("settle_early", en_steer, 0);
        pulse(12'h700, 12'h100, 1'b0);
        pulse(12'h300, 12'h300, 1'b0);
        repeat (32767) step();
        chk("settle_tc_minus1", en_steer, 0);
        step();
        chk("settle_tc", en_steer, 1);

        // STEER exits
        pulse(12'h700, 12'h100, 1'b0);
        chk("steer_imbal_keeps", en_steer, 1);
        pulse(12'h600, 12'h010, 1'b0);
        chk("step_off_drop", en_steer, 0);
        chk("step_off_pwr_up", pwr_up, 1);

        // Rider hysteresis band 0x1C0..0x240
        pulse(12'h0D8, 12'h0D8, 1'b0);
        chk("hyst_sum_1B0", rider_off, 1);
        pulse(12'h108, 12'h108, 1'b0);
        chk("hyst_sum_210_hold1", rider_off, 1);
        pulse(12'h120, 12'h120, 1'b0);
        chk("hyst_sum_240_hold1", rider_off, 1);
        pulse(12'h121, 12'h120, 1'b0);
        chk("hyst_sum_241", rider_off, 0);
        pulse(12'h0E0, 12'h0E0, 1'b0);
        chk("hyst_sum_1C0_hold0", rider_off, 0);
        pulse(12'h108, 12'h108, 1'b0);
        chk("hyst_sum_210_hold0", rider_off, 0);

        // Overspeed: 3 samples, break, then 4 consecutive
        for (int i = 0; i < 3; i++) pulse(12'h300, 12'h300, 1'b1);
        chk("ovr_after_3", ovr_spd, 0);
        pulse(12'h300, 12'h300, 1'b0);
        for (int i = 0; i < 3; i++) pulse(12'h300, 12'h300, 1'b1);
        chk("ovr_after_break_3", ovr_spd, 0);
        pulse(12'h300, 12'h300, 1'b1);
        chk("ovr_latched", ovr_spd, 1);
        chk("ovr_en_steer", en_steer, 0);
        chk("ovr_pwr_up", pwr_up, 1);
        chk("ovr_ss_tmr", ss_tmr, 8'hFF);
        repeat (33000) step();
        chk("ovr_inhibit_steer", en_steer, 0);
        chk("ovr_held", ovr_spd, 1);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("async_pwr_up",    pwr_up,    0);
        chk("async_ss_tmr",    ss_tmr,    0);
        chk("async_ovr_spd",   ovr_spd,   0);
        chk("async_rider_off", rider_off, 1);
        chk("async_en_steer",  en_steer,  0);
        step();
        rst_n = 1'b1;
        step();

        // Power drop mid-ramp
        chk("reramp_ss_start", ss_tmr, 8'h00);
        vld = 1'b1;
        repeat (128) step();
        vld = 1'b0;
        chk("ramp_ss_80", ss_tmr, 8'h80);
        pwr_req = 1'b0;
        step();
        chk("drop_ramp_pwr_up", pwr_up, 0);
        chk("drop_ramp_ss_tmr", ss_tmr, 8'h00);

        // Power drop with an overspeed fault latched
        pwr_req = 1'b1;
        step();
        vld = 1'b1;
        repeat (255) step();
        vld = 1'b0;
        chk("reramp_ss_full", ss_tmr, 8'hFF);
        for (int i = 0; i < 4; i++) pulse(12'h300, 12'h300, 1'b1);
        chk("ovr2_latched", ovr_spd, 1);
        pwr_req = 1'b0;
        step();
        chk("drop_ovr_pwr_up",   pwr_up,   0);
        chk("drop_ovr_ss_tmr",   ss_tmr,   8'h00);
        chk("drop_ovr_en_steer", en_steer, 0);
        chk("drop_ovr_ovr_spd",  ovr_spd,  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
